// File: rtl/de1_soc_button_pkg.sv
`default_nettype none
// ============================================================================
// Module  : de1_soc_button_pkg
// Brief   : Register offsets and debounce state encoding for the button block.
// Revision: 1.0 - initial release
// ============================================================================
package de1_soc_button_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_EDGESEL = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    typedef enum logic [0:0] {
        ST_STABLE = 1'b0,
        ST_VERIFY = 1'b1
    } deb_state_e;

endpackage
`default_nettype wire

// File: rtl/de1_soc_debounce.sv
`default_nettype none
// ============================================================================
// Module  : de1_soc_debounce
// Brief   : One button line: polarity fix, 2-flop sync, counter debounce FSM.
// Revision: 1.0 - initial release
// ============================================================================
module de1_soc_debounce
    import de1_soc_button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_pin,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [CNT_W-1:0] c_last_cnt  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_first_cnt = CNT_W'(1);

    logic             w_pressed;
    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q, stable_d;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign w_pressed = (ACTIVE_LOW != 0) ? ~i_pin : i_pin;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            state_q  <= ST_STABLE;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= w_pressed;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
        end
    end

    // The detecting cycle counts as the first held cycle, so the level must
    // differ from stable for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        o_rise   = 1'b0;
        o_fall   = 1'b0;
        case (state_q)
            ST_STABLE: begin
                cnt_d = '0;
                if (sync2_q != stable_q) begin
                    state_d = ST_VERIFY;
                    cnt_d   = c_first_cnt;
                end
            end
            ST_VERIFY: begin
                if (sync2_q == stable_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == c_last_cnt) begin
                    stable_d = sync2_q;
                    o_rise   = sync2_q;
                    o_fall   = ~sync2_q;
                    state_d  = ST_STABLE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + c_first_cnt;
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign o_stable = stable_q;

endmodule
`default_nettype wire

// File: rtl/de1_soc_button_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : de1_soc_button_ctrl
// Brief   : Avalon-MM push-button controller; BUTTON_CTRL_RELEASE_EDGE_EN adds
//           the EDGESEL register for release-edge capture.
// Revision: 1.0 - initial release
// ============================================================================
module de1_soc_button_ctrl
    import de1_soc_button_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge_set;
    logic [WIDTH-1:0] w_edgesel_rd;
    logic             w_wr;
    logic             w_unused_wdata;

    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
            de1_soc_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W),
                .ACTIVE_LOW      (ACTIVE_LOW)
            ) u_debounce (
                .clk      (clk),
                .reset_n  (reset_n),
                .i_pin    (in_port[i]),
                .o_stable (w_stable[i]),
                .o_rise   (w_rise[i]),
                .o_fall   (w_fall[i])
            );
        end
    endgenerate

    assign w_wr           = chipselect && !write_n;
    assign w_unused_wdata = ^writedata;

`ifdef BUTTON_CTRL_RELEASE_EDGE_EN
    logic [WIDTH-1:0] edgesel_q, edgesel_d;

    always_comb begin
        edgesel_d = edgesel_q;
        if (w_wr && (address == ADDR_EDGESEL)) begin
            edgesel_d = writedata[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgesel_q <= '0;
        end else begin
            edgesel_q <= edgesel_d;
        end
    end

    assign w_edge_set   = w_rise | (w_fall & edgesel_q);
    assign w_edgesel_rd = edgesel_q;
`else
    logic w_unused_fall;
    assign w_unused_fall = ^w_fall;
    assign w_edge_set    = w_rise;
    assign w_edgesel_rd  = '0;
`endif

    always_comb begin
        irq_mask_d     = irq_mask_q;
        edge_capture_d = edge_capture_q;
        if (w_wr && (address == ADDR_IRQMASK)) begin
            irq_mask_d = writedata[WIDTH-1:0];
        end
        if (w_wr && (address == ADDR_EDGECAP)) begin
            edge_capture_d = edge_capture_d & ~writedata[WIDTH-1:0];
        end
        // Set is applied after the clear so a same-cycle event is never lost.
        edge_capture_d = edge_capture_d | w_edge_set;

        irq_d = |(edge_capture_q & irq_mask_q);

        readdata_d = '0;
        case (address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = w_stable;
            ADDR_EDGESEL: readdata_d[WIDTH-1:0] = w_edgesel_rd;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edge_capture_q;
            default:      readdata_d            = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
            readdata_q     <= '0;
            irq_q          <= 1'b0;
        end else begin
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            readdata_q     <= readdata_d;
            irq_q          <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule
`default_nettype wire
